// File: rtl/rv_core_pkg.sv
// Shared core types for register-file writeback arbitration.
// Latency: none (types and constants only).
// Backpressure: not applicable.
// Contents: ADDR_W/DATA_W defaults, arbiter state enum, REG_ZERO index.
package rv_core_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  // Register index that is hardwired to zero; writes to it are suppressed.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE1 = 1'b1
  } arbState_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of the two writeback request channels plus the register-file write port.
// Latency: none (wiring only).
// Backpressure: req*_ready driven by the arbiter; the write port never stalls.
// Ports: req0_*/req1_* valid/rd/data/ready, RegWrite/WriteRegister/WriteData, starving.
// Modports: slave = arbiter side, master = requesters + register file side.
interface rf_wb_arbiter_if
  import rv_core_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_rd;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_rd;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              starving;

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready,
    output RegWrite, WriteRegister, WriteData, starving
  );

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready,
    input  RegWrite, WriteRegister, WriteData, starving
  );

endinterface

// File: rtl/rf_wb_grant.sv
// Combinational grant decision between the WB stage (0) and the long-latency unit (1).
// Latency: zero, purely combinational.
// Backpressure: a grant is only ever raised for a requester whose valid is high.
// Inputs: req0Valid, req1Valid, state.  Outputs: grant0, grant1 (one-hot or zero).
module rf_wb_grant
  import rv_core_pkg::*;
(
  input  logic      req0Valid,
  input  logic      req1Valid,
  input  arbState_t state,
  output logic      grant0,
  output logic      grant1
);

  // FORCE1 only overrides priority while requester 1 still wants the port;
  // otherwise the decision falls back to plain fixed priority.
  logic force1;

  assign force1 = (state == FORCE1) & req1Valid;
  assign grant0 = req0Valid & ~force1;
  assign grant1 = req1Valid & (force1 | ~req0Valid);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the WB stage and the long-latency unit.
// Latency: one cycle from accept to RegWrite/WriteRegister/WriteData.
// Backpressure: readys are combinational; requester 1 is forced through after MAX_WAIT denials.
// Ports: clk, reset (sync, active-high), bus (rf_wb_arbiter_if.slave).
// Optional: RF_WB_ARB_PERF_EN adds conflict_cnt[31:0] and forced_cnt[15:0].
module rf_wb_arbiter
  import rv_core_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  rf_wb_arbiter_if.slave bus
`ifdef RF_WB_ARB_PERF_EN
  ,
  output logic [31:0]   conflict_cnt,
  output logic [15:0]   forced_cnt
`endif
);

  localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] RD_ZERO    = ADDR_W'(REG_ZERO);

  arbState_t         state;
  logic              starvingQ;
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] waitNext;

  logic              grant0;
  logic              grant1;
  logic              accept0;
  logic              accept1;
  logic [ADDR_W-1:0] selRd;
  logic [DATA_W-1:0] selData;

  logic              regWriteQ;
  logic [ADDR_W-1:0] writeRegisterQ;
  logic [DATA_W-1:0] writeDataQ;

  rf_wb_grant uGrant (
    .req0Valid (bus.req0_valid),
    .req1Valid (bus.req1_valid),
    .state     (state),
    .grant0    (grant0),
    .grant1    (grant1)
  );

  // Nothing is accepted while reset is high, so a request parked across
  // reset is taken on the first cycle after it.
  assign accept0 = grant0 & ~reset;
  assign accept1 = grant1 & ~reset;

  assign bus.req0_ready = accept0;
  assign bus.req1_ready = accept1;

  assign selRd   = accept0 ? bus.req0_rd   : bus.req1_rd;
  assign selData = accept0 ? bus.req0_data : bus.req1_data;

  // Counts consecutive cycles requester 1 was valid but denied.
  always_comb begin
    waitNext = waitCnt;
    if (!bus.req1_valid || accept1) begin
      waitNext = '0;
    end else if (waitCnt != WAIT_LIMIT) begin
      waitNext = waitCnt + WAIT_W'(1);
    end
  end

  // The FORCE1 decision uses the updated count so that the forced grant lands
  // exactly MAX_WAIT cycles after requester 1 first went unserved.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= NORMAL;
      starvingQ <= 1'b0;
      waitCnt   <= '0;
    end else begin
      waitCnt <= waitNext;
      case (state)
        NORMAL: begin
          if (waitNext == WAIT_LIMIT) begin
            state     <= FORCE1;
            starvingQ <= 1'b1;
          end
        end
        FORCE1: begin
          if (!bus.req1_valid || accept1) begin
            state     <= NORMAL;
            starvingQ <= 1'b0;
          end
        end
        default: begin
          state     <= NORMAL;
          starvingQ <= 1'b0;
        end
      endcase
    end
  end

  // x0 writes are granted but never reach the register file; the port
  // keeps showing the last real write in that case.
  always_ff @(posedge clk) begin
    if (reset) begin
      regWriteQ      <= 1'b0;
      writeRegisterQ <= '0;
      writeDataQ     <= '0;
    end else begin
      regWriteQ <= 1'b0;
      if ((accept0 || accept1) && (selRd != RD_ZERO)) begin
        regWriteQ      <= 1'b1;
        writeRegisterQ <= selRd;
        writeDataQ     <= selData;
      end
    end
  end

  assign bus.RegWrite      = regWriteQ;
  assign bus.WriteRegister = writeRegisterQ;
  assign bus.WriteData     = writeDataQ;
  assign bus.starving      = starvingQ;

`ifdef RF_WB_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt <= '0;
      forced_cnt   <= '0;
    end else begin
      if (bus.req0_valid && bus.req1_valid) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
      if ((state == FORCE1) && accept1 && (forced_cnt != 16'hFFFF)) begin
        forced_cnt <= forced_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (RegWrite / WriteRegister / WriteData) between two writeback sources.
  - Requester 0: the in-order pipeline WB stage.
  - Requester 1: the long-latency unit (MUL/DIV, LSU miss return).
- Fixed priority to requester 0, with a starvation guard that forces a requester-1 grant after MAX_WAIT denied cycles.
- The write port is registered: one-cycle latency from accept to write.

Parameters:
- ADDR_W, 5, register index width.
- DATA_W, 32, write data width.
- MAX_WAIT, 4, consecutive denied cycles tolerated for requester 1 before a forced grant; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  WB-stage write request.
- req0_rd  input  ADDR_W  WB-stage destination register.
- req0_data  input  DATA_W  WB-stage write data.
- req0_ready  output  1  WB-stage request accepted this cycle.
- req1_valid  input  1  long-latency unit write request.
- req1_rd  input  ADDR_W  long-latency destination register.
- req1_data  input  DATA_W  long-latency write data.
- req1_ready  output  1  long-latency request accepted this cycle.
- RegWrite  output  1  register-file write enable.
- WriteRegister  output  ADDR_W  register-file write index.
- WriteData  output  DATA_W  register-file write data.
- starving  output  1  high while in the FORCE1 state.

Behaviour:
- Reset: RegWrite=0, WriteRegister=0, WriteData=0, wait_cnt=0, state=NORMAL.
  - A request presented in the reset cycle is not accepted: both readys are 0 during reset.
- Handshake: a requester holds valid/rd/data stable until its ready is high. Accept = valid & ready in the same cycle.
- readys are combinational from the valids and state. At most one ready is high per cycle, and only when the matching valid is high.
- FSM states:
  - NORMAL: grant req0 if req0_valid; else grant req1 if req1_valid.
  - FORCE1: grant req1 if req1_valid (req0_ready=0, pipeline stalls); if req1_valid has dropped, behave as NORMAL.
- wait_cnt (saturating, width clog2(MAX_WAIT+1)):
  - Increments when req1_valid & !req1_ready.
  - Clears to 0 on a req1 accept or when req1_valid=0.
- Transitions:
  - NORMAL -> FORCE1 when wait_cnt reaches MAX_WAIT.
  - FORCE1 -> NORMAL on a req1 accept or when req1_valid=0.
  - Worst-case req1 wait is therefore MAX_WAIT cycles.
- Output stage: on accept at edge N, the captured rd/data appear on WriteRegister/WriteData at N+1, with RegWrite=1 for exactly one cycle.
  - No accept: RegWrite=0; WriteRegister/WriteData hold their last values.
- x0 writes: a request with rd=0 is accepted normally but produces RegWrite=0. It still counts as a grant for the FSM and wait_cnt.
- Both requesters target the same rd in one cycle: only the granted one is written; the other is written on a later cycle (last write wins). Ordering between the sources is the issuing logic's responsibility.
- Back-to-back: one accept per cycle, sustained; the output stage never back-pressures.
- Reset mid-operation: the pending output write is dropped (RegWrite=0 next cycle), state=NORMAL, wait_cnt=0.

Optional Feature:
- Macro: RF_WB_ARB_PERF_EN.
- Defined:
  - Adds output conflict_cnt [31:0]: counts cycles with req0_valid & req1_valid; wraps at 2^32; reset to 0.
  - Adds output forced_cnt [15:0]: counts FORCE1 grants; saturates at 16'hFFFF; reset to 0.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Decomposition:
- Shared package rv_core_pkg:
  - ADDR_W/DATA_W defaults.
  - Arbiter state typedef {NORMAL, FORCE1}.
  - Constant REG_ZERO = 0.
- One natural sub-module: rf_wb_grant, the combinational grant logic (inputs valids, state; outputs grant0/grant1).
- State, counters and the output register stay in rf_wb_arbiter.

Test Plan:
- Reset held 2 cycles with req0_valid=1 -> both readys 0, RegWrite=0. First post-reset cycle: req0_ready=1.
- req0 only, rd=5, data=32'hDEADBEEF -> next cycle RegWrite=1, WriteRegister=5, WriteData=32'hDEADBEEF; a register-file read of x5 afterwards returns 32'hDEADBEEF.
- req0 and req1 continuously valid, MAX_WAIT=4 -> req0 granted cycles 0-3, req1 granted cycle 4 with starving=1, then req0 resumes; the pattern repeats.
- req1 rd=0, data=32'h1234 -> req1_ready=1, RegWrite stays 0, x0 still reads 0.
- Both valid with rd=7 (req0 data=1, req1 data=2) -> x7=1 after cycle 1; req1 is written later, so the final x7=2.
- Reset asserted in the cycle after an accept -> RegWrite=0; state=NORMAL and wait_cnt=0 are confirmed by 4 further denied cycles before FORCE1.
